// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame width, FSM state codes and
// the width helper used to size the oversampling tick counter.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high
// line level so no phantom start edge is seen after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic nrst,
  input  logic rx,
  output logic rx_s
);

  logic meta_r;
  logic sync_r;

  // Two-stage metastability filter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
    end
  end

  assign rx_s = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8N2 framing, oversampled line, mid-bit sampling aligned
// to each start edge, one-cycle valid / frame_err pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int STOP       = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

  logic                 rx_s;
  rx_state_e            state_r;
  logic [TW-1:0]        tick_r;
  logic [2:0]           bit_idx_r;
  logic                 stop_idx_r;
  logic                 bad_r;
  logic                 done_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [7:0]           data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 busy_r;

  uart_rx_sync u_sync (
    .clk  (clk),
    .nrst (nrst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // Receive FSM with datapath; all outputs are registered here
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= ST_IDLE;
      tick_r      <= '0;
      bit_idx_r   <= 3'd0;
      stop_idx_r  <= 1'b0;
      bad_r       <= 1'b0;
      done_r      <= 1'b0;
      shift_r     <= '0;
      data_r      <= 8'h00;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) begin
            state_r <= ST_START;
            tick_r  <= '0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_START: begin
          if (tick_r == HALF_TICK) begin
            if (rx_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              tick_r    <= '0;
              bit_idx_r <= 3'd0;
              state_r   <= ST_DATA;
            end
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_r == LAST_TICK) begin
            tick_r  <= '0;
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
              state_r    <= ST_STOP;
              stop_idx_r <= 1'b0;
              bad_r      <= 1'b0;
              done_r     <= 1'b0;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_STOP: begin
          // The frame verdict is issued one cycle after the last stop sample
          if (done_r) begin
            done_r <= 1'b0;
            if (bad_r) begin
              frame_err_r <= 1'b1;
              state_r     <= ST_BREAK;
            end else begin
              valid_r <= 1'b1;
              data_r  <= shift_r;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else if (tick_r == LAST_TICK) begin
            tick_r <= '0;
            if (!rx_s) begin
              bad_r <= 1'b1;
            end
            if (stop_idx_r == 1'(STOP - 1)) begin
              done_r <= 1'b1;
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end else begin
            tick_r <= tick_r + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8 data bits, LSB first, no parity, STOP stop bits. It pairs with the UART_TX line format.
- Samples the serial line with a clock running at OVERSAMPLE times the bit rate.
- Re-aligns to each start-bit falling edge and delivers each received byte with a one-cycle valid pulse.
- Sits between the external RX pin and the byte consumer (FIFO or command parser).

Parameters:
- STOP, 1, number of stop bits checked (1 or 2).
- OVERSAMPLE, 16, clk cycles per bit period; must be even and >= 4.

Ports:
- clk  input  1  sampling clock, OVERSAMPLE x bit rate.
- nrst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data  output  8  last correctly framed byte; held until the next good frame.
- valid  output  1  one-cycle pulse; data is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when a stop bit samples 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous on nrst low:
  - data = 0, valid = 0, frame_err = 0, busy = 0.
  - Synchronizer flops = 1; state = IDLE; counters = 0.
- Synchronizer:
  - Two flops on rx give rx_s. The FSM uses only rx_s.
  - Input-to-rx_s latency is 2 clk.
- Counters:
  - Tick counter is clog2(OVERSAMPLE) bits; bit index is 0..7.
  - Shift register is 8 bits; it shifts right and takes the new bit into [7].
- IDLE: when rx_s = 0, go to START and clear the tick counter. Call this edge E.
- START:
  - Sample rx_s at E + OVERSAMPLE/2 (mid start bit).
  - rx_s = 1: false start; go to IDLE with no pulse.
  - rx_s = 0: clear the tick counter, bit index = 0, go to DATA.
- DATA:
  - Data bit k is sampled at E + OVERSAMPLE/2 + (k+1)*OVERSAMPLE.
  - After bit 7, go to STOP.
- STOP:
  - Stop bit j (0..STOP-1) is sampled at E + OVERSAMPLE/2 + (9+j)*OVERSAMPLE.
  - Any stop sample of 0 marks the frame bad.
  - After the last stop sample, take the outcome on the next edge:
    - Good frame: data <= shift register, valid = 1 for one cycle, go to IDLE.
    - Bad frame: frame_err = 1 for one cycle, data unchanged, go to BREAK.
- BREAK: stay (busy = 1) until rx_s = 1, then go to IDLE. A held-low line therefore produces exactly one frame_err.
- Return to IDLE happens mid-stop-bit. A start edge arriving up to OVERSAMPLE/2 clocks early on back-to-back frames is still captured.
- valid and frame_err are never high in the same cycle. Neither fires outside the cycle right after the last stop sample.
- Baud tolerance: frames are received correctly with a transmitter bit-rate error of up to +/-3% at OVERSAMPLE = 16.
- Reset mid-frame: the partial byte is discarded. No valid or frame_err pulse is emitted for it.
- State encoding: IDLE, START, DATA, STOP, BREAK (3 bits).

Decomposition:
- Shared uart_defs include: DATA_BITS = 8, rx state codes, clog2 helper for the tick-counter width.
- One natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.
- The FSM and datapath stay in uart_rx.

Test Plan:
- 0x5A frame, STOP = 1, OVERSAMPLE = 16 -> valid pulse exactly 152 clk after E + 1, data = 0x5A, frame_err never high.
- rx glitch low for 4 clk from idle -> busy high for 8 clk then low; no valid, no frame_err.
- 0x3C with the stop bit driven 0, line held low 3 bit times after -> one frame_err pulse, data stays 0x5A, busy stays high until rx returns to 1.
- UART_TX loopback, TX run at the bit rate: back-to-back bytes 0x5A, 0x2B, 0x00, 0xFF, 0x1C, 0x5E, 0x04, 0x13, 0x7D, 0x65, 0x2E, 0x81, 0x09, 0xAB, 0x51, 0x2D -> 16 valid pulses, bytes in order, no frame_err.
- nrst pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately; the following 0x81 frame is received correctly.
- STOP = 2, transmitter rate +3% then -3%, byte 0xAB -> data = 0xAB with valid in both runs; stop bit 2 forced 0 -> frame_err.
